muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide engine in the EX stage, beside the ALU.
//  Its start/resp pair drives the pipeline hazard unit's M-extension stall
//  inputs (muldiv_start, muldiv_resp): the pipeline freezes while the unit is busy.
//  It computes all eight RV32M ops at 1 bit/cycle: shift-add multiply and
//  restoring divide, on operand magnitudes with sign fix-up at the end.
// PARAMETERS
//  WIDTH        32  operand/result width; the only supported value is 32
//  DIV_FASTPATH 1   1: div-by-zero and signed overflow complete in 1 cycle
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous active-high reset
//  start        in   1      M-op in EX; held high until resp, then dropped or next op
//  funct3       in   3      000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  rs1_data     in   WIDTH  operand a (dividend)
//  rs2_data     in   WIDTH  operand b (divisor)
//  resp         out  1      1-cycle pulse: result is valid (to hazard unit muldiv_resp)
//  busy         out  1      high in BUSY state
//  result       out  WIDTH  registered result; stable from resp until the next accept
// BEHAVIOUR
//  Reset: state=IDLE, resp=0, busy=0, result=0, internal accumulators=0.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE: start=1 at a clk edge -> latch funct3, |a|, |b|, sign flags; cnt=0; go to BUSY.
//         With DIV_FASTPATH, a div-by-zero or overflow op goes to DONE instead.
//   BUSY: one iteration per edge; cnt increments; after iteration 32 go to DONE.
//         start=0 in BUSY (flush) -> abort to IDLE; no resp; result unchanged.
//   DONE: resp=1 for exactly one cycle and result is updated; start is ignored here.
//         Next state is IDLE, so a back-to-back op is accepted one cycle after resp.
//  Latency: start first seen in cycle 0 -> resp in cycle 33 (normal case).
//   Fast path -> resp in cycle 1.
//  Multiply: 64-bit unsigned product of the magnitudes.
//   Negate the product if the signs differ.
//   MUL returns the low word; MULH, MULHSU and MULHU return the high word.
//   Signedness: MULH treats a and b as signed; MULHSU treats a as signed, b as unsigned.
//   MULHU treats both as unsigned.
//  Divide: restoring algorithm on the magnitudes.
//   Quotient is negated if the signs differ; remainder takes the dividend's sign.
//   DIVU and REMU use the raw unsigned operands.
//  Special cases (apply with or without fast path):
//   b==0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return a.
//   a==0x80000000 and b==0xFFFFFFFF, signed: DIV returns 0x80000000; REM returns 0.
//  Magnitudes: |0x80000000| is held as unsigned 0x80000000; no overflow occurs internally.
//  rs1_data, rs2_data and funct3 are sampled only at accept.
//   Changes to them during BUSY are ignored.
//  rst=1 in any state -> IDLE next cycle; resp=0; in-flight op discarded.
// TESTING
//  MUL 7 x -3 (0x7, 0xFFFFFFFD): resp in cycle 33, result=0xFFFFFFEB; resp high 1 cycle.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000.
//   MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
//   DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000.
//   Each of these: resp in cycle 1 when DIV_FASTPATH=1, cycle 33 when 0.
//  Back-to-back: MUL 3x4 then start held high with DIVU 9/3.
//   Required: results 12 then 3; second accept exactly 1 cycle after the first resp; no duplicate resp.
//  Abort and reset: drop start in cycle 10 of BUSY -> IDLE, no resp.
//   Assert rst in cycle 20 of another op -> resp=0, result=0, busy=0 next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide engine that sits beside the ALU in EX.
//   It retires one bit per cycle. Multiply uses shift-add and divide uses the
//   restoring algorithm. Both work on operand magnitudes, and the sign is
//   fixed up when the result is written. The start/resp pair feeds the hazard
//   unit, which freezes the pipeline while an op is in flight.
//
// Ports
//   clk       in   1      clock
//   rst       in   1      synchronous active-high reset
//   start     in   1      M-op present in EX, held until resp (dropping it
//                         while busy aborts the op)
//   funct3    in   3      RV32M operation select
//   rs1_data  in   WIDTH  operand a / dividend
//   rs2_data  in   WIDTH  operand b / divisor
//   resp      out  1      one-cycle pulse, result valid
//   busy      out  1      iterating
//   result    out  WIDTH  registered result, held until the next accept
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH        = 32,
    parameter bit DIV_FASTPATH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             resp,
    output logic             busy,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Two's-complement negate under control of a flag.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
        return neg ? -x : x;
    endfunction

    // Sign fix-up and word selection once all iterations are complete.
    function automatic logic [WIDTH-1:0] finalize(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic             a_neg,
                                                  input logic             b_neg,
                                                  input logic             b_zero);
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] prod_fix;
        prod     = {hi, lo};
        prod_fix = (a_neg ^ b_neg) ? -prod : prod;
        if (!op[2]) begin
            return (op == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end else if (!op[1]) begin
            // A zero divisor yields an all-ones quotient whatever the dividend sign.
            return cond_neg(lo, (a_neg ^ b_neg) & ~b_zero);
        end else begin
            return cond_neg(hi, a_neg);
        end
    endfunction

    // Single-cycle answer for divide by zero and signed overflow.
    // In both cases the quotient and remainder follow directly from a.
    function automatic logic [WIDTH-1:0] fast_result(input logic [2:0]       op,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic             b_zero);
        if (op[1]) begin
            return b_zero ? a : '0;
        end else begin
            return b_zero ? '1 : a;
        end
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_q, resp_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic signed [WIDTH-1:0] a_sgn, b_sgn;
    logic               in_signed_a, in_signed_b;
    logic               in_a_neg, in_b_neg, in_b_zero, in_ovf;
    logic [WIDTH-1:0]   in_a_mag, in_b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;

    always_comb begin
        // Operand decode at accept
        a_sgn       = rs1_data;
        b_sgn       = rs2_data;
        in_signed_a = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                      (funct3 == OP_DIV) || (funct3 == OP_REM);
        in_signed_b = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
                      (funct3 == OP_DIV) || (funct3 == OP_REM);
        in_a_neg    = in_signed_a && (a_sgn < 0);
        in_b_neg    = in_signed_b && (b_sgn < 0);
        // |0x80000000| stays 0x80000000 as an unsigned magnitude.
        in_a_mag    = cond_neg(rs1_data, in_a_neg);
        in_b_mag    = cond_neg(rs2_data, in_b_neg);
        in_b_zero   = funct3[2] && (rs2_data == '0);
        in_ovf      = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                      (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (&rs2_data);

        // One iteration step. {hi,lo} is the product/multiplier pair for
        // multiply and the remainder/quotient pair for divide.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_mag_q});
        // The true difference fits in WIDTH bits whenever it is kept.
        div_sub   = div_shift[WIDTH-1:0] - b_mag_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        state_d  = state_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_mag_d  = b_mag_q;
        cnt_d    = cnt_q;
        resp_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = funct3;
                    a_neg_d  = in_a_neg;
                    b_neg_d  = in_b_neg;
                    b_zero_d = in_b_zero;
                    hi_d     = '0;
                    lo_d     = in_a_mag;
                    b_mag_d  = in_b_mag;
                    cnt_d    = '0;
                    if (DIV_FASTPATH && (in_b_zero || in_ovf)) begin
                        state_d  = S_DONE;
                        resp_d   = 1'b1;
                        result_d = fast_result(funct3, rs1_data, in_b_zero);
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!start) begin
                    // The pipeline flushed the op, so drop it silently.
                    state_d = S_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = S_DONE;
                        resp_d   = 1'b1;
                        result_d = finalize(op_q, step_hi, step_lo, a_neg_q, b_neg_q, b_zero_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_mag_q  <= '0;
            cnt_q    <= '0;
            resp_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_mag_q  <= b_mag_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            busy_q   <= busy_d;
            result_q <= result_d;
        end
    end

    assign resp   = resp_q;
    assign busy   = busy_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Bench for muldiv_unit (DIV_FASTPATH=1). It runs a table of fixed vectors,
//   then random vectors checked against a reference model, and then
//   hand-written sequences for back-to-back issue, abort and reset. Expected
//   results go into a scoreboard queue when an op is driven and are popped
//   when resp arrives.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        resp;
    logic        busy;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .DIV_FASTPATH(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .resp     (resp),
        .busy     (busy),
        .result   (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    vec_t        vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model built on the simulator's own signed/unsigned arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one op starting in cycle 0 and wait for resp. Operands are
    // scrambled while the op is busy, which must not affect the result.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int          lat;
        bit          got;
        logic [31:0] exp_r;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (resp) got = 1'b1;
            else begin
                rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom);
            end
        end
        exp_r = sb_q.pop_front();
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no resp within %0d cycles, required latency %0d", name, lat, exp_lat);
            start = 1'b0;
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(exp_lat));
            check({name, "_result"}, result, exp_r);
            start = 1'b0;
            @(posedge clk); #1;
            check({name, "_resp_pulse"}, {31'd0, resp}, 32'd0);
            check({name, "_result_hold"}, result, exp_r);
        end
    endtask

    initial begin
        int          lat;
        int          n;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd5, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd4, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[14] = '{3'd3, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33};
        vecs[15] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33};

        rst = 1'b1; start = 1'b0; funct3 = 3'd0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp",   {31'd0, resp}, 32'd0);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 20));
            run_op($sformatf("rand%0d", i), rf, ra, rb, ref_op(rf, ra, rb), ref_lat(rf, ra, rb));
        end

        // Back-to-back: start stays high across resp with the next op waiting.
        sb_q.push_back(32'd12);
        sb_q.push_back(32'd3);
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4;
        lat = 0;
        while (!resp && lat < 40) begin @(posedge clk); #1; lat++; end
        check("b2b_first_latency", 32'(lat), 32'd33);
        check("b2b_first_result", result, sb_q.pop_front());
        funct3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd3;
        @(posedge clk); #1;
        check("b2b_no_dup_resp", {31'd0, resp}, 32'd0);
        check("b2b_idle_gap_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("b2b_second_accept_busy", {31'd0, busy}, 32'd1);
        n = 2;
        while (!resp && n < 60) begin @(posedge clk); #1; n++; end
        check("b2b_second_gap", 32'(n), 32'd34);
        check("b2b_second_result", result, sb_q.pop_front());
        start = 1'b0;
        @(posedge clk); #1;

        // Abort: drop start in cycle 10 of BUSY; no resp and the result holds.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6;
        for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp) n++;
            @(posedge clk); #1;
        end
        check("abort_no_resp", 32'(n), 32'd0);
        check("abort_result_hold", result, 32'd3);

        // Reset in cycle 20 of an op.
        start = 1'b1; funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd10;
        for (int c = 1; c <= 20; c++) begin @(posedge clk); #1; end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_resp",   {31'd0, resp}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        run_op("post_rst_mul", 3'd0, 32'd6, 32'd7, 32'd42, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
